instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Reader side of the instruction memory. Owns the program counter and drives the memory's combinational address port. Captures each returned 32-bit instruction into a single output register and presents it to decode with a valid/ready handshake. Handles redirects from branch/jump resolution and stops fetching on a HALT opcode.

Parameters:
DATA_WIDTH, 32, instruction width; field layout opcode[31:27] rd[26:22] rs1[21:17] rs2[16:12] imm[11:0]
ADDR_WIDTH, 8, PC / memory address width (word addressed)
RESET_PC, 0, PC value loaded at reset
HALT_OPCODE, 5'b11111, opcode that stops fetching

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching at the current PC
imem_addr  out  ADDR_WIDTH  address to instruction memory (= pc, combinational)
imem_instr  in  DATA_WIDTH  instruction from memory, valid in the same cycle as imem_addr
redirect_valid  in  1  one-cycle pulse: load new PC, flush output
redirect_addr  in  ADDR_WIDTH  redirect target
out_valid  out  1  out_instr/out_pc hold a valid instruction
out_ready  in  1  decode accepts when out_valid && out_ready
out_instr  out  DATA_WIDTH  registered instruction
out_pc  out  ADDR_WIDTH  address out_instr was fetched from
halted  out  1  high while in HALT state
fetch_count  out  16  number of instructions loaded into the output register since reset; wraps at 16 bits

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
- States: IDLE, RUN, HALT.
  - IDLE: start=1 -> RUN. No fetch is performed in the IDLE cycle.
  - RUN: fetch on every edge where load = (!out_valid || out_ready).
  - HALT: no fetches; halted=1.
- load in RUN: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1 (mod 2^ADDR_WIDTH, 255 wraps to 0), fetch_count<=fetch_count+1.
  - Result: one instruction per cycle while out_ready=1; latency of 1 cycle from address to out_valid.
- Stall: out_valid && !out_ready -> pc, out_instr and out_pc are held stable; no fetch.
- Handshake without a new load (e.g. in HALT): out_valid && out_ready -> out_valid<=0 on that edge.
- Redirect priority: redirect_valid beats load, stall and halt detection, in any state except IDLE.
  - Effect: pc<=redirect_addr, out_valid<=0 (held instruction discarded; the handshake in that cycle does not count as accepted), state<=RUN (also exits HALT).
  - The first instruction from the target appears with out_valid=1 one edge later.
  - Redirect while IDLE is ignored.
- HALT detection: when load captures an instruction with opcode==HALT_OPCODE, it is emitted normally and state<=HALT; pc still increments.
- start while RUN or HALT: ignored.
- Reset mid-operation: all state returns immediately to the reset values; any in-flight instruction is lost.

Optional Feature:
FETCH_JUMP_PREDECODE_EN
- Defined: when load captures opcode 5'b10010 (JUMP), the instruction is still emitted, but the next pc is imm[ADDR_WIDTH-1:0] instead of pc+1.
  - No redirect from downstream is needed for JUMP.
  - An external redirect in the same cycle still has priority.
- Undefined: JUMP is treated as an ordinary instruction; pc<=pc+1.

Test Plan:
- Reset, start, out_ready=1, memory holds ADD/SUB at 0,1 -> out_valid rises 1 cycle after start; out_pc=0,1,2… on consecutive cycles; out_instr matches memory at each address; fetch_count increments each cycle.
- Hold out_ready=0 for 3 cycles at out_pc=5 -> out_instr/out_pc/imem_addr=6 stable for 3 cycles; release -> out_pc=6 next cycle; no skipped or duplicated PC.
- redirect_valid with redirect_addr=40 while out_valid=1, out_pc=10 -> next edge out_valid=0; following edge out_pc=40, out_instr=mem[40].
- Word 3 = HALT_OPCODE -> instruction 3 emitted, halted=1, out_valid=0 after acceptance, pc stays 4; redirect to 0 -> resumes at out_pc=0, halted=0.
- Start at pc=254 with sequential code -> out_pc 254, 255, 0, 1 (wrap).
- With FETCH_JUMP_PREDECODE_EN, word 27 = JUMP imm=35 -> out_pc sequence 27, 35. Without the macro -> 27, 28.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Purpose: bundles the bus signals around the fetch unit. That means the
// instruction-memory read port, the redirect request from branch/jump
// resolution, and the valid/ready output channel toward decode.
//
// Modports:
//   master - fetch unit side. Drives imem_addr and the out_* channel.
//            Receives imem_instr, the redirect request and out_ready.
//   slave  - environment side (memory, branch resolution, decode).
//
// Signals:
//   imem_addr      address to instruction memory (combinational from pc)
//   imem_instr     instruction returned in the same cycle as imem_addr
//   redirect_valid one-cycle pulse requesting a PC reload and output flush
//   redirect_addr  redirect target
//   out_valid      out_instr/out_pc hold a valid instruction
//   out_ready      decode accepts when out_valid && out_ready
//   out_instr      registered instruction
//   out_pc         address out_instr was fetched from
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose: reader side of the instruction memory. The unit owns the program
// counter and drives it combinationally as the memory address. It captures
// the returned instruction into a single output register, which decode
// drains through a valid/ready handshake. Redirects from branch/jump
// resolution reload the PC and flush the output register. Fetching stops
// after an instruction with opcode HALT_OPCODE is captured.
//
// Instruction fields: opcode[31:27] rd[26:22] rs1[21:17] rs2[16:12] imm[11:0]
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        leave IDLE and begin fetching at the current PC
//   bus          instruction_fetch_unit_if.master (imem, redirect, output channel)
//   halted       high while in HALT state
//   fetch_count  instructions loaded into the output register since reset (wraps)
//
// Optional feature macro: FETCH_JUMP_PREDECODE_EN
//   Defined   -> a captured JUMP (opcode 5'b10010) steers the next PC to
//                imm[ADDR_WIDTH-1:0] instead of pc+1.
//   Undefined -> JUMP is fetched like any other instruction.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int              DATA_WIDTH  = 32,
  parameter int              ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OPCODE = 5'b11111
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  instruction_fetch_unit_if.master    bus,
  output logic                        halted,
  output logic [15:0]                 fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic [4:0] JUMP_OPCODE = 5'b10010;
`endif

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_instr_reg, out_instr_next;
  logic [ADDR_WIDTH-1:0] out_pc_reg, out_pc_next;
  logic [15:0]           fetch_count_reg, fetch_count_next;

  logic                  load;
  logic [4:0]            fetched_opcode;

  assign fetched_opcode = bus.imem_instr[DATA_WIDTH-1 -: 5];

  // The output register is free when it is empty or is being drained this cycle.
  assign load = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      out_valid_reg   <= 1'b0;
      out_instr_reg   <= '0;
      out_pc_reg      <= '0;
      fetch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      out_valid_reg   <= out_valid_next;
      out_instr_reg   <= out_instr_next;
      out_pc_reg      <= out_pc_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    out_valid_next   = out_valid_reg;
    out_instr_next   = out_instr_reg;
    out_pc_next      = out_pc_reg;
    fetch_count_next = fetch_count_reg;

    unique case (state_reg)
      IDLE: begin
        // Redirects are ignored here. Only start leaves IDLE, and no fetch
        // happens in this cycle.
        if (start) begin
          state_next = RUN;
        end
      end

      RUN, HALT: begin
        if (bus.redirect_valid) begin
          // A redirect outranks everything else. Any held instruction is
          // dropped, even if decode is handshaking it in this same cycle.
          pc_next        = bus.redirect_addr;
          out_valid_next = 1'b0;
          state_next     = RUN;
        end else if (load) begin
          out_instr_next   = bus.imem_instr;
          out_pc_next      = pc_reg;
          out_valid_next   = 1'b1;
          fetch_count_next = fetch_count_reg + 16'd1;
          pc_next          = pc_reg + 1'b1;
`ifdef FETCH_JUMP_PREDECODE_EN
          if (fetched_opcode == JUMP_OPCODE) begin
            pc_next = bus.imem_instr[ADDR_WIDTH-1:0];
          end
`endif
          // HALT is still emitted, and the PC still advances past it.
          if (fetched_opcode == HALT_OPCODE) begin
            state_next = HALT;
          end
        end else if (out_valid_reg && bus.out_ready) begin
          // Decode accepted the output, but no new fetch replaces it
          // (only reachable in HALT).
          out_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_pc    = out_pc_reg;
  assign halted        = (state_reg == HALT);
  assign fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. A behavioural 256-word memory
// answers imem_addr combinationally. Stimulus is driven 1 time unit after
// each rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:255];

  int err_count;
  int check_count;

  instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  assign bus.imem_instr = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    err_count   = 0;
    check_count = 0;

    // Memory image: even words use opcode 1, odd words use opcode 2,
    // and imm holds the word address. Word 3 is HALT and word 27 is JUMP 35.
    for (int i = 0; i < 256; i++) begin
      mem[i] = {((i % 2) != 0) ? 5'd2 : 5'd1, 15'h0, 12'(i)};
    end
    mem[3]  = {5'b11111, 27'h0};
    mem[27] = {5'b10010, 15'h0, 12'd35};

    rst_n              = 1'b0;
    start              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 8'd0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_pc", 32'(bus.out_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // A redirect while IDLE must be ignored.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd50;
    tick();
    bus.redirect_valid = 1'b0;
    check("idle_redirect_ignored", 32'(bus.imem_addr), 32'd0);
    check("idle_no_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- start and sequential fetch ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cycle_no_fetch", 32'(bus.out_valid), 32'd0);
    check("start_cycle_fc", 32'(fetch_count), 32'd0);
    tick();
    check("seq0_valid", 32'(bus.out_valid), 32'd1);
    check("seq0_pc", 32'(bus.out_pc), 32'd0);
    check("seq0_instr", bus.out_instr, 32'h0800_0000);
    check("seq0_fc", 32'(fetch_count), 32'd1);
    tick();
    check("seq1_pc", 32'(bus.out_pc), 32'd1);
    check("seq1_instr", bus.out_instr, 32'h1000_0001);
    check("seq1_fc", 32'(fetch_count), 32'd2);
    tick();
    check("seq2_pc", 32'(bus.out_pc), 32'd2);
    check("seq2_fc", 32'(fetch_count), 32'd3);

    // ---------------- HALT ----------------
    tick();
    check("halt_emit_pc", 32'(bus.out_pc), 32'd3);
    check("halt_emit_instr", bus.out_instr, 32'hF800_0000);
    check("halt_emit_valid", 32'(bus.out_valid), 32'd1);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc_advanced", 32'(bus.imem_addr), 32'd4);
    tick();
    check("halt_accept_valid", 32'(bus.out_valid), 32'd0);
    check("halt_pc_held", 32'(bus.imem_addr), 32'd4);
    tick();
    check("halt_no_fetch_fc", 32'(fetch_count), 32'd4);
    check("halt_still", 32'(halted), 32'd1);

    // A redirect to 0 leaves HALT.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd0;
    tick();
    bus.redirect_valid = 1'b0;
    check("resume_valid0", 32'(bus.out_valid), 32'd0);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    check("resume_pc", 32'(bus.out_pc), 32'd0);
    check("resume_valid", 32'(bus.out_valid), 32'd1);
    check("resume_fc", 32'(fetch_count), 32'd5);

    // ---------------- stall ----------------
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd5;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("pre_stall_pc", 32'(bus.out_pc), 32'd5);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_pc", k), 32'(bus.out_pc), 32'd5);
      check($sformatf("stall%0d_instr", k), bus.out_instr, mem[5]);
      check($sformatf("stall%0d_addr", k), 32'(bus.imem_addr), 32'd6);
      check($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    check("stall_fc", 32'(fetch_count), 32'd6);
    bus.out_ready = 1'b1;
    tick();
    check("unstall_pc6", 32'(bus.out_pc), 32'd6);
    check("unstall_instr6", bus.out_instr, 32'h0800_0006);
    tick();
    check("unstall_pc7", 32'(bus.out_pc), 32'd7);

    // ---------------- redirect while valid ----------------
    tick();
    tick();
    tick();
    check("pre_redir_pc", 32'(bus.out_pc), 32'd10);
    check("pre_redir_fc", 32'(fetch_count), 32'd11);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd40;
    tick();
    bus.redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(bus.out_valid), 32'd0);
    check("redir_addr", 32'(bus.imem_addr), 32'd40);
    check("redir_fc", 32'(fetch_count), 32'd11);
    tick();
    check("redir_target_pc", 32'(bus.out_pc), 32'd40);
    check("redir_target_instr", bus.out_instr, 32'h0800_0028);
    check("redir_target_valid", 32'(bus.out_valid), 32'd1);

    // ---------------- PC wrap ----------------
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd254;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("wrap_pc254", 32'(bus.out_pc), 32'd254);
    tick();
    check("wrap_pc255", 32'(bus.out_pc), 32'd255);
    check("wrap_addr0", 32'(bus.imem_addr), 32'd0);
    tick();
    check("wrap_pc0", 32'(bus.out_pc), 32'd0);
    tick();
    check("wrap_pc1", 32'(bus.out_pc), 32'd1);

    // ---------------- JUMP predecode ----------------
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd27;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("jump_pc27", 32'(bus.out_pc), 32'd27);
    check("jump_instr27", bus.out_instr, 32'h9000_0023);
    tick();
`ifdef FETCH_JUMP_PREDECODE_EN
    check("jump_next_pc", 32'(bus.out_pc), 32'd35);
    check("jump_next_instr", bus.out_instr, 32'h1000_0023);
`else
    check("jump_next_pc", 32'(bus.out_pc), 32'd28);
    check("jump_next_instr", bus.out_instr, 32'h0800_001C);
`endif

    // ---------------- asynchronous reset mid-operation ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_fc", 32'(fetch_count), 32'd0);
    check("async_rst_addr", 32'(bus.imem_addr), 32'd0);
    check("async_rst_pc", 32'(bus.out_pc), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
